// File: rtl/capture_buffer_pkg.sv
// Shared types and constants for the byte capture buffer.
// The state encoding is fixed so firmware can decode it from debug dumps.
package capture_buffer_pkg;

    localparam int DEFAULT_ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        CAPTURE = 2'b10,
        DONE    = 2'b11
    } capture_state_t;

endpackage

// File: rtl/capture_buffer_if.sv
// Data-path bundle of the capture buffer: upstream byte stream in, SPI RAM read port.
// The master side is the producer/reader (pipeline tap plus SPI slave), the slave side is the buffer.
interface capture_buffer_if
    import capture_buffer_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    modport master (
        output in_data,
        output in_valid,
        output rd_en,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  rd_en,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/capture_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// Only the read register is reset, so the array maps onto block RAM.
module capture_ram
    import capture_buffer_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A read colliding with a write to the same address sees the old byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 8'h00;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/capture_buffer.sv
// Arm/trigger controlled byte capture into a RAM that the SPI slave drains.
// Holds the capture FSM, the write counter and the latched capture length.
module capture_buffer
    import capture_buffer_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic              trigger,
    input  logic [ADDR_W-1:0] length,
    capture_buffer_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count
);
    localparam logic [ADDR_W:0] FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    capture_state_t  state_reg, state_next;
    logic [ADDR_W:0] count_reg, count_next;
    logic [ADDR_W:0] target_reg, target_next;
    logic [ADDR_W:0] count_inc;
    logic            wr_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            target_reg <= FULL_DEPTH;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            target_reg <= target_next;
        end
    end

    // Abort beats arm; arm is only honoured outside CAPTURE.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        target_next = target_reg;
        wr_fire     = 1'b0;
        count_inc   = count_reg + COUNT_ONE;

        if (abort) begin
            state_next = IDLE;
        end else if (arm && (state_reg != CAPTURE)) begin
            state_next  = ARMED;
            count_next  = '0;
            target_next = (length == '0) ? FULL_DEPTH : {1'b0, length};
        end else begin
            case (state_reg)
                ARMED: begin
                    if (trigger) begin
                        state_next = CAPTURE;
                        wr_fire    = bus.in_valid;
                    end
                end
                CAPTURE: begin
                    wr_fire = bus.in_valid;
                end
                default: begin
                end
            endcase

            // The byte accompanying trigger is byte 0, so a one-byte capture skips CAPTURE.
            if (wr_fire) begin
                count_next = count_inc;
                if (count_inc == target_reg) begin
                    state_next = DONE;
                end
            end
        end
    end

    assign busy     = (state_reg == ARMED) || (state_reg == CAPTURE);
    assign done     = (state_reg == DONE);
    assign wr_count = count_reg;

    capture_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (reset),
        .we    (wr_fire),
        .waddr (count_reg[ADDR_W-1:0]),
        .wdata (bus.in_data),
        .re    (bus.rd_en),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );

endmodule

// File: tb/tb_capture_buffer.sv
// Self-checking bench for capture_buffer with a small (16-byte) memory.
// Table vectors, hand sequences for corner cases, then random traffic against a queue-level model.
module tb_capture_buffer;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          arm     = 1'b0;
    logic          abort   = 1'b0;
    logic          trigger = 1'b0;
    logic [AW-1:0] length  = '0;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;

    capture_buffer_if #(.ADDR_W(AW)) bus ();

    capture_buffer #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .arm      (arm),
        .abort    (abort),
        .trigger  (trigger),
        .length   (length),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 idle, 1 armed, 2 capturing, 3 finished.
    int         m_mode;
    int         m_count;
    int         m_target;
    logic [7:0] m_mem [DEPTH];
    bit         m_known [DEPTH];
    logic [7:0] m_rd;
    bit         m_rd_known;

    typedef struct {
        bit arm;
        bit abort;
        bit trigger;
        int length;
        bit in_valid;
        int in_data;
        bit rd_en;
        int rd_addr;
        bit e_busy;
        bit e_done;
        int e_count;
        bit chk_rd;
        int e_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(bit a, bit ab, bit tr, int len, bit v, int d, bit re, int ra);
        arm          = a;
        abort        = ab;
        trigger      = tr;
        length       = AW'(len);
        bus.in_valid = v;
        bus.in_data  = 8'(d);
        bus.rd_en    = re;
        bus.rd_addr  = AW'(ra);
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_count    = 0;
        m_target   = DEPTH;
        m_rd       = 8'h00;
        m_rd_known = 1'b1;
    endtask

    task automatic model_step();
        int  a;
        bit  take;
        if (bus.rd_en) begin
            a          = int'(bus.rd_addr);
            m_rd       = m_mem[a];
            m_rd_known = m_known[a];
        end
        if (abort) begin
            m_mode = 0;
        end else if (arm && m_mode != 2) begin
            m_mode   = 1;
            m_count  = 0;
            m_target = (length == 0) ? DEPTH : int'(length);
        end else if (m_mode == 1 || m_mode == 2) begin
            take = bus.in_valid && (m_mode == 2 || trigger);
            if (m_mode == 1 && trigger) m_mode = 2;
            if (take) begin
                m_mem[m_count % DEPTH]   = bus.in_data;
                m_known[m_count % DEPTH] = 1'b1;
                m_count++;
                if (m_count == m_target) m_mode = 3;
            end
        end
    endtask

    task automatic check_model(string tag);
        check({tag, ".busy"}, int'(busy), int'(m_mode == 1 || m_mode == 2));
        check({tag, ".done"}, int'(done), int'(m_mode == 3));
        check({tag, ".wr_count"}, int'(wr_count), m_count);
        if (m_rd_known) check({tag, ".rd_data"}, int'(bus.rd_data), int'(m_rd));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = 8'h00;
        end
        idle_inputs();
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.wr_count", int'(wr_count), 0);
        check("reset.rd_data", int'(bus.rd_data), 0);
        reset = 1'b0;
        $display("reset released: busy=%0d done=%0d wr_count=%0d", busy, done, wr_count);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, i);
            cycle();
            $display("post-reset read addr %0d rd_data=%02h", i, bus.rd_data);
        end
        idle_inputs();
        cycle();

        // Full-depth capture: length 0, 21 bytes offered, first 16 kept
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("full.armed", int'(busy), 1);
        for (int i = 0; i < 21; i++) begin
            drive(0, 0, i == 0, 0, 1, i, 0, 0);
            cycle();
            check("full.wr_count", int'(wr_count), (i + 1 < DEPTH) ? i + 1 : DEPTH);
            check("full.done", int'(done), int'(i >= DEPTH - 1));
            $display("full byte %02h: wr_count=%0d done=%0d", i, wr_count, done);
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, i);
            cycle();
            check("full.read", int'(bus.rd_data), i);
            $display("full read addr %0d rd_data=%02h", i, bus.rd_data);
        end

        // Table vectors: length-4 capture, trailing byte dropped, reads, ignored trigger
        tbl.push_back('{1, 0, 0, 4, 0, 'h00, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 4, 1, 'hAA, 0, 0, 1, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 4, 1, 'h01, 0, 0, 1, 0, 2, 0, 0});
        tbl.push_back('{0, 0, 0, 4, 1, 'h02, 0, 0, 1, 0, 3, 0, 0});
        tbl.push_back('{0, 0, 0, 4, 1, 'h03, 0, 0, 0, 1, 4, 0, 0});
        tbl.push_back('{0, 0, 0, 4, 1, 'h55, 1, 4, 0, 1, 4, 1, 'h04});
        tbl.push_back('{0, 0, 0, 4, 0, 'h00, 1, 0, 0, 1, 4, 1, 'hAA});
        tbl.push_back('{0, 0, 0, 4, 0, 'h00, 1, 1, 0, 1, 4, 1, 'h01});
        tbl.push_back('{0, 0, 0, 4, 0, 'h00, 1, 2, 0, 1, 4, 1, 'h02});
        tbl.push_back('{0, 0, 0, 4, 0, 'h00, 1, 3, 0, 1, 4, 1, 'h03});
        tbl.push_back('{0, 0, 0, 4, 0, 'h00, 0, 2, 0, 1, 4, 1, 'h03});
        tbl.push_back('{0, 0, 1, 4, 1, 'h77, 0, 0, 0, 1, 4, 0, 0});
        tbl.push_back('{1, 0, 0, 4, 1, 'h66, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 4, 1, 'h66, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 4, 0, 'h00, 0, 0, 0, 0, 0, 0, 0});
        foreach (tbl[r]) begin
            drive(tbl[r].arm, tbl[r].abort, tbl[r].trigger, tbl[r].length,
                  tbl[r].in_valid, tbl[r].in_data, tbl[r].rd_en, tbl[r].rd_addr);
            cycle();
            check($sformatf("tbl%0d.busy", r), int'(busy), int'(tbl[r].e_busy));
            check($sformatf("tbl%0d.done", r), int'(done), int'(tbl[r].e_done));
            check($sformatf("tbl%0d.wr_count", r), int'(wr_count), tbl[r].e_count);
            if (tbl[r].chk_rd) check($sformatf("tbl%0d.rd_data", r), int'(bus.rd_data), tbl[r].e_rd);
            $display("row %0d: busy=%0d done=%0d wr_count=%0d rd_data=%02h",
                     r, busy, done, wr_count, bus.rd_data);
        end

        // Abort keeps count and memory; arm+abort stays idle; trigger in idle writes nothing
        drive(1, 0, 0, 8, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 1, 8, 1, 'hC1, 0, 0);
        cycle();
        drive(0, 0, 0, 8, 1, 'hC2, 0, 0);
        cycle();
        check("abort.pre_count", int'(wr_count), 2);
        drive(0, 1, 0, 8, 0, 0, 0, 0);
        cycle();
        check("abort.busy", int'(busy), 0);
        check("abort.done", int'(done), 0);
        check("abort.wr_count", int'(wr_count), 2);
        drive(1, 1, 0, 8, 0, 0, 0, 0);
        cycle();
        check("arm_abort.busy", int'(busy), 0);
        check("arm_abort.wr_count", int'(wr_count), 2);
        drive(0, 0, 1, 8, 1, 'hEE, 0, 0);
        cycle();
        check("idle_trig.busy", int'(busy), 0);
        check("idle_trig.wr_count", int'(wr_count), 2);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();
        check("abort.mem0", int'(bus.rd_data), 'hC1);
        drive(0, 0, 0, 0, 0, 0, 1, 2);
        cycle();
        check("abort.mem2", int'(bus.rd_data), 'h02);
        $display("abort sequence: wr_count=%0d busy=%0d", wr_count, busy);

        // Read-during-write: seed address 3 with 00, then overwrite with 5A while reading it
        drive(1, 0, 0, 8, 0, 0, 0, 0);
        cycle();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, i == 0, 8, 1, 'h00, 0, 0);
            cycle();
        end
        check("raw.seed_done", int'(done), 1);
        drive(1, 0, 0, 8, 0, 0, 0, 0);
        cycle();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, i == 0, 8, 1, (i == 3) ? 'h5A : 'h20 + i, i == 3 || i == 4, 3);
            cycle();
            if (i == 3) check("raw.old", int'(bus.rd_data), 'h00);
            if (i == 4) check("raw.new", int'(bus.rd_data), 'h5A);
        end
        check("raw.done", int'(done), 1);
        $display("read-during-write: rd_data=%02h done=%0d", bus.rd_data, done);

        // Asynchronous reset mid-capture, then a clean re-capture
        drive(1, 0, 0, 8, 0, 0, 1, 1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, i == 0, 8, 1, 'hD0 + i, 0, 0);
            cycle();
        end
        check("rstmid.pre_count", int'(wr_count), 3);
        reset = 1'b1;
        #1;
        check("rstmid.busy", int'(busy), 0);
        check("rstmid.done", int'(done), 0);
        check("rstmid.wr_count", int'(wr_count), 0);
        check("rstmid.rd_data", int'(bus.rd_data), 0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 0, 2, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 1, 2, 1, 'hE0, 0, 0);
        cycle();
        drive(0, 0, 0, 2, 1, 'hE1, 0, 0);
        cycle();
        check("recap.done", int'(done), 1);
        check("recap.wr_count", int'(wr_count), 2);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        cycle();
        check("recap.mem1", int'(bus.rd_data), 'hE1);
        $display("re-capture after reset: wr_count=%0d done=%0d", wr_count, done);

        // Length 1 with trigger: single write, straight to done
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 1, 1, 1, 'h9C, 0, 0);
        cycle();
        check("len1.done", int'(done), 1);
        check("len1.wr_count", int'(wr_count), 1);
        drive(0, 0, 0, 1, 1, 'h9D, 1, 0);
        cycle();
        check("len1.mem0", int'(bus.rd_data), 'h9C);
        check("len1.mem1", int'(bus.rd_data) == 'h9D ? 1 : 0, 0);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 255),
                  $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1));
            cycle();
            check_model($sformatf("rand%0d", n));
        end
        $display("random phase: %0d cycles, model wr_count=%0d", 800, m_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/capture_buffer.md
# capture_buffer

Byte capture buffer that fills the debug RAM later drained over SPI by the host's debug read opcodes (8-, 16- and 32-bit RAM reads). Upstream pipeline bytes (camera, display or audio taps) are written into an on-chip pseudo-dual-port memory after an arm/trigger sequence. The read port is exactly the SPI slave's RAM interface: address, enable, data.

## Interface
Parameters:
- ADDR_W, 17, memory address width; depth = 2**ADDR_W bytes

Ports:
- clk  in  1  main system clock
- reset  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle pulse; latches length, clears pointer, enters ARMED
- abort  in  1  single-cycle pulse; returns to IDLE from any state
- trigger  in  1  single-cycle pulse; starts capture when ARMED
- length  in  ADDR_W  bytes to capture, sampled on arm; 0 means full depth (2**ADDR_W)
- in_data  in  8  upstream byte
- in_valid  in  1  in_data qualifier, one byte per cycle max
- rd_en  in  1  read enable from the SPI slave
- rd_addr  in  ADDR_W  read byte address from the SPI slave
- rd_data  out  8  registered read data
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  high in DONE
- wr_count  out  ADDR_W+1  bytes written in current/last capture

## Operation
- States: IDLE (00), ARMED (01), CAPTURE (10), DONE (11).
- IDLE --arm--> ARMED; ARMED --trigger--> CAPTURE; CAPTURE --wr_count reaches target--> DONE; DONE --arm--> ARMED.
- abort from any state -> IDLE; wr_count and memory contents preserved.
- abort and arm in same cycle: abort wins.
- arm in ARMED: re-latches length, wr_count cleared, stays ARMED. arm in CAPTURE: ignored.
- trigger outside ARMED: ignored.
- target = length when length != 0, else 2**ADDR_W. Compare in ADDR_W+1 bits.
- Write condition: in_valid and (state == CAPTURE or (state == ARMED and trigger)).
  - The byte arriving with trigger is byte 0.
- On write: mem[wr_count[ADDR_W-1:0]] <= in_data, wr_count <= wr_count + 1.
- in_valid in IDLE, DONE, or ARMED without trigger: byte dropped, no state change.
- Read port independent of FSM; reads are legal in every state.
- Read-during-write to the same address returns the old byte.
- Memory is not cleared by reset or arm.

## Timing
- Reset values: state IDLE, wr_count 0, rd_data 8'h00, busy 0, done 0.
- Reset mid-capture: immediate return to IDLE, wr_count 0.
- wr_count updates the cycle after the accepted write.
- Transition to DONE is registered: done rises the cycle after the final write.
- Bytes offered in the final-write cycle +1 onward are dropped.
- length = 1 with trigger+in_valid in ARMED: one write, DONE on the next cycle (CAPTURE is bypassed for the final write).
- Read latency is 1 cycle: rd_en high at edge N with rd_addr A gives rd_data = mem[A] after edge N.
- rd_en low: rd_data holds its last value.
- busy and done are decoded from the state register; they have no combinational input paths.

## Structure
- Package capture_buffer_pkg:
  - state enum capture_state_t (IDLE, ARMED, CAPTURE, DONE)
  - default ADDR_W constant
- Sub-module capture_ram:
  - simple dual-port: one write port (we, waddr, wdata), one registered read port (re, raddr, rdata)
  - inferred as EBR/LRAM; no reset on the array
  - rdata reset to 0
- FSM, counter and length latch live in capture_buffer.

## Test plan
- Reset, then read addresses 0..3 with rd_en -> rd_data 8'h00 until first read edge, no X on outputs; state IDLE, wr_count 0.
- arm with length=4; trigger+in_valid with bytes AA,01,02,03 on consecutive cycles, then 55 -> done rises one cycle after 03, wr_count=4, reads 0..3 return AA,01,02,03, address 4 not written.
- ADDR_W=4, length=0, continuous in_valid counting 00..14 -> 16 bytes 00..0F stored, wr_count=16, 10..14 dropped, done asserted.
- arm, trigger, 2 bytes written, abort -> IDLE, wr_count=2. arm+abort same cycle -> IDLE. trigger in IDLE -> no writes.
- In CAPTURE, read address k in the same cycle k is written with 5A (old value 00) -> rd_data 00; next read of k -> 5A.
- Assert reset for one cycle mid-capture at wr_count=3 -> outputs return to reset values asynchronously; re-arm and capture succeed.
